// File: rtl/taus88_pkg.sv
// taus88_pkg: shared types and constants for the taus88 scheduler
// (taus88_sched and its round-robin picker taus_rr_arb).
package taus88_pkg;

  localparam int TAUS_W            = 32;
  localparam int SETTLE_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    RESEED = 2'd1,
    SETTLE = 2'd2
  } sched_state_e;

  // Bits needed to index n items; never less than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/taus_rr_arb.sv
// taus_rr_arb: combinational round-robin picker. Searches req starting one
// position after i_ptr (wrapping at NUM_REQ) and returns the first hit as a
// one-hot vector and as an index. The pointer register lives in the caller.
module taus_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [PTR_W-1:0]   o_idx,
  output logic               o_any
);

  logic [PTR_W-1:0] w_cand;

  // Walk the requesters in priority order and keep the first one found.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = PTR_W'((int'(i_ptr) + k) % NUM_REQ);
      if (!o_any && i_req[w_cand]) begin
        o_any            = 1'b1;
        o_onehot[w_cand] = 1'b1;
        o_idx            = w_cand;
      end
    end
  end

endmodule

// File: rtl/taus88_sched.sv
// taus88_sched: shares one free-running taus88 generator among NUM_REQ
// consumers (one grant per cycle, round-robin) and sequences reseeding.
// Reseed requests beat grants; after a reseed, grants stay blocked for
// SETTLE_CYCLES cycles while the generator state flushes.
// Build option: define TAUS_SCHED_STATS_EN to add per-requester saturating
// grant counters (stat_clr / stat_cnt ports).
module taus88_sched
  import taus88_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int STAT_W        = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
`ifdef TAUS_SCHED_STATS_EN
  input  logic                      stat_clr,
  output logic [NUM_REQ*STAT_W-1:0] stat_cnt,
`endif
  input  logic [NUM_REQ-1:0]        req,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [TAUS_W-1:0]         rnd_data,
  output logic                      rnd_valid,
  input  logic                      reseed_req,
  input  logic [TAUS_W-1:0]         reseed_seed,
  output logic                      reseed_ack,
  output logic                      busy,
  output logic [TAUS_W-1:0]         taus_seed,
  output logic                      taus_re_seed,
  input  logic [TAUS_W-1:0]         taus_rnd
);

  localparam int               PTR_W    = clog2(NUM_REQ);
  localparam int               CNT_W    = clog2(SETTLE_CYCLES);
  localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  generate
    if (NUM_REQ < 2 || NUM_REQ > 16 || SETTLE_CYCLES < 1 || STAT_W < 1) begin : g_bad_param
      $error("taus88_sched: parameter out of range");
    end
  endgenerate

  sched_state_e        r_state;
  logic [CNT_W-1:0]    r_settle;
  logic [PTR_W-1:0]    r_ptr;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [TAUS_W-1:0]   r_rnd;
  logic                r_ack;
  logic                r_re_seed;
  logic [TAUS_W-1:0]   r_taus_seed;

  logic [NUM_REQ-1:0]  w_onehot;
  logic [PTR_W-1:0]    w_idx;
  logic                w_any;
  logic                w_start_reseed;
  logic                w_grant;

  taus_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  // A reseed may start from RUN, or straight from the last SETTLE cycle when
  // a new request is already waiting (no RUN cycle in between).
  assign w_start_reseed = reseed_req &&
                          ((r_state == RUN) || ((r_state == SETTLE) && (r_settle == '0)));
  assign w_grant        = (r_state == RUN) && !reseed_req && w_any;

  // Control FSM: RUN -> RESEED (1 cycle) -> SETTLE (SETTLE_CYCLES) -> RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_settle    <= '0;
      r_ack       <= 1'b0;
      r_re_seed   <= 1'b0;
      r_taus_seed <= '0;
    end else begin
      r_ack     <= w_start_reseed;
      r_re_seed <= w_start_reseed;
      if (w_start_reseed) r_taus_seed <= reseed_seed;
      unique case (r_state)
        RUN: begin
          if (reseed_req) r_state <= RESEED;
        end
        RESEED: begin
          r_state  <= SETTLE;
          r_settle <= CNT_LOAD;
        end
        SETTLE: begin
          if (r_settle != '0) r_settle <= r_settle - CNT_W'(1);
          else if (reseed_req) r_state <= RESEED;
          else r_state <= RUN;
        end
        default: r_state <= RUN;
      endcase
    end
  end

  // Grant datapath: register the one-hot winner with the current word and
  // move the round-robin pointer to the winner; the word holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt <= '0;
      r_rnd <= '0;
      r_ptr <= PTR_RST;
    end else begin
      r_gnt <= '0;
      if (w_grant) begin
        r_gnt <= w_onehot;
        r_rnd <= taus_rnd;
        r_ptr <= w_idx;
      end
    end
  end

  assign gnt          = r_gnt;
  assign rnd_data     = r_rnd;
  assign rnd_valid    = |r_gnt;
  assign reseed_ack   = r_ack;
  assign taus_re_seed = r_re_seed;
  assign taus_seed    = r_taus_seed;
  assign busy         = (r_state != RUN);

`ifdef TAUS_SCHED_STATS_EN
  logic [NUM_REQ-1:0][STAT_W-1:0] r_stat;

  // Per-requester grant counters: clear beats increment, saturate at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat <= '0;
    end else if (stat_clr) begin
      r_stat <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (r_gnt[i] && (r_stat[i] != '1)) r_stat[i] <= r_stat[i] + STAT_W'(1);
      end
    end
  end

  assign stat_cnt = r_stat;
`else
  // Without the statistics option there are no grant counters.
`endif

endmodule

// File: tb/tb_taus88_sched.sv
// tb_taus88_sched: directed bench for taus88_sched. A small stand-in for the
// external taus88 produces a word per cycle indexed by edges since its last
// re_seed sample; for the seeds used here it returns taus88 reference words.
module tb_taus88_sched;

  localparam int NUM_REQ = 4;
  localparam int STAT_W  = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic [31:0] rnd_data;
  logic        rnd_valid;
  logic        reseed_req;
  logic [31:0] reseed_seed;
  logic        reseed_ack;
  logic        busy;
  logic [31:0] taus_seed;
  logic        taus_re_seed;
  logic [31:0] taus_rnd;
`ifdef TAUS_SCHED_STATS_EN
  logic                      stat_clr;
  logic [NUM_REQ*STAT_W-1:0] stat_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  taus88_sched #(
    .NUM_REQ       (NUM_REQ),
    .SETTLE_CYCLES (2),
    .STAT_W        (STAT_W)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef TAUS_SCHED_STATS_EN
    .stat_clr     (stat_clr),
    .stat_cnt     (stat_cnt),
`endif
    .req          (req),
    .gnt          (gnt),
    .rnd_data     (rnd_data),
    .rnd_valid    (rnd_valid),
    .reseed_req   (reseed_req),
    .reseed_seed  (reseed_seed),
    .reseed_ack   (reseed_ack),
    .busy         (busy),
    .taus_seed    (taus_seed),
    .taus_re_seed (taus_re_seed),
    .taus_rnd     (taus_rnd)
  );

  // Generator stand-in: word index restarts at 0 on the re_seed sample edge.
  logic [31:0] stub_seed    = 32'h1357_9BDF;
  int unsigned stub_n       = 0;
  int          reseed_edges = 0;

  always @(posedge clk) begin
    if (taus_re_seed) begin
      stub_seed    <= taus_seed;
      stub_n       <= 0;
      reseed_edges <= reseed_edges + 1;
    end else begin
      stub_n <= stub_n + 1;
    end
  end

  function automatic logic [31:0] word_f(input logic [31:0] s, input int unsigned n);
    logic [31:0] w;
    w = s ^ (n * 32'h9E37_79B9) ^ 32'h0F0F_1234;
    if (s == 32'hDEAD_BEEF) begin
      if (n == 2) w = 32'd3687771566;
      else if (n == 3) w = 32'd4006792393;
      else if (n == 4) w = 32'd1712068217;
    end else if (s == 32'hCAFE_BABE && n == 2) begin
      w = 32'd3951813429;
    end
    return w;
  endfunction

  assign taus_rnd = word_f(stub_seed, stub_n);

  // Observation buffers filled by the observe() stimulus helper.
  logic [31:0] got_word [16];
  logic [3:0]  got_gnt  [16];
  int          got_n;
  int          busy_n;
  int          ack_n;

  // Step negedges until n_words grants are seen or the budget runs out;
  // drops reseed_req as soon as an ack is seen.
  task automatic observe(input int n_words, input int budget);
    got_n  = 0;
    busy_n = 0;
    ack_n  = 0;
    for (int c = 0; c < budget && got_n < n_words; c++) begin
      @(negedge clk);
      if (reseed_ack) begin
        ack_n++;
        reseed_req = 1'b0;
      end
      if (busy) busy_n++;
      if (rnd_valid && got_n < 16) begin
        got_word[got_n] = rnd_data;
        got_gnt[got_n]  = gnt;
        got_n++;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    req        = 4'b0000;
    reseed_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    req         = 4'b0000;
    reseed_req  = 1'b0;
    reseed_seed = 32'h0;
`ifdef TAUS_SCHED_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt: got %b expected %b", gnt, 4'b0000); end
    checks++; if (rnd_data !== 32'h0) begin failures++; $display("FAIL reset_rnd_data: got %h expected %h", rnd_data, 32'h0); end
    checks++; if (rnd_valid !== 1'b0) begin failures++; $display("FAIL reset_rnd_valid: got %b expected 0", rnd_valid); end
    checks++; if (reseed_ack !== 1'b0) begin failures++; $display("FAIL reset_ack: got %b expected 0", reseed_ack); end
    checks++; if (taus_re_seed !== 1'b0) begin failures++; $display("FAIL reset_re_seed: got %b expected 0", taus_re_seed); end
    checks++; if (taus_seed !== 32'h0) begin failures++; $display("FAIL reset_taus_seed: got %h expected %h", taus_seed, 32'h0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst_n = 1'b1;
  endtask

  task automatic test_first_grant();
    logic [31:0] exp_w;
    @(negedge clk);
    req   = 4'b0001;
    exp_w = taus_rnd;
    @(negedge clk);
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL first_gnt: got %b expected %b", gnt, 4'b0001); end
    checks++; if (rnd_data !== exp_w) begin failures++; $display("FAIL first_word: got %h expected %h", rnd_data, exp_w); end
    checks++; if (rnd_valid !== 1'b1) begin failures++; $display("FAIL first_valid: got %b expected 1", rnd_valid); end
    req = 4'b0000;
    @(negedge clk);
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL idle_gnt: got %b expected %b", gnt, 4'b0000); end
    checks++; if (rnd_valid !== 1'b0) begin failures++; $display("FAIL idle_valid: got %b expected 0", rnd_valid); end
    checks++; if (rnd_data !== exp_w) begin failures++; $display("FAIL idle_hold: got %h expected %h", rnd_data, exp_w); end
  endtask

  task automatic test_reseed_single();
    int e0;
    @(negedge clk);
    req         = 4'b0001;
    reseed_req  = 1'b1;
    reseed_seed = 32'hDEAD_BEEF;
    e0          = reseed_edges;
    @(negedge clk);
    checks++; if (reseed_ack !== 1'b1) begin failures++; $display("FAIL rs_ack: got %b expected 1", reseed_ack); end
    checks++; if (taus_re_seed !== 1'b1) begin failures++; $display("FAIL rs_re_seed: got %b expected 1", taus_re_seed); end
    checks++; if (taus_seed !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rs_seed: got %h expected %h", taus_seed, 32'hDEAD_BEEF); end
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL rs_priority_gnt: got %b expected %b", gnt, 4'b0000); end
    reseed_req  = 1'b0;
    reseed_seed = 32'h0;
    observe(3, 20);
    req = 4'b0000;
    checks++; if (ack_n !== 0) begin failures++; $display("FAIL rs_ack_extra: got %0d expected 0", ack_n); end
    checks++; if (busy_n + 1 !== 3) begin failures++; $display("FAIL rs_busy_cycles: got %0d expected 3", busy_n + 1); end
    checks++; if (got_n !== 3) begin failures++; $display("FAIL rs_grant_count: got %0d expected 3", got_n); end
    checks++; if (got_word[0] !== 32'd3687771566) begin failures++; $display("FAIL rs_word0: got %0d expected 3687771566", got_word[0]); end
    checks++; if (got_word[1] !== 32'd4006792393) begin failures++; $display("FAIL rs_word1: got %0d expected 4006792393", got_word[1]); end
    checks++; if (got_word[2] !== 32'd1712068217) begin failures++; $display("FAIL rs_word2: got %0d expected 1712068217", got_word[2]); end
    checks++; if (taus_seed !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rs_seed_hold: got %h expected %h", taus_seed, 32'hDEAD_BEEF); end
    checks++; if (reseed_edges - e0 !== 1) begin failures++; $display("FAIL rs_edges: got %0d expected 1", reseed_edges - e0); end
  endtask

  task automatic test_reseed_shared();
    do_reset();
    @(negedge clk);
    req         = 4'b0011;
    reseed_req  = 1'b1;
    reseed_seed = 32'hDEAD_BEEF;
    observe(3, 20);
    req = 4'b0000;
    checks++; if (got_n !== 3) begin failures++; $display("FAIL sh_grant_count: got %0d expected 3", got_n); end
    checks++; if (got_gnt[0] !== 4'b0001 || got_word[0] !== 32'd3687771566) begin failures++; $display("FAIL sh_grant0: got %b/%0d expected 0001/3687771566", got_gnt[0], got_word[0]); end
    checks++; if (got_gnt[1] !== 4'b0010 || got_word[1] !== 32'd4006792393) begin failures++; $display("FAIL sh_grant1: got %b/%0d expected 0010/4006792393", got_gnt[1], got_word[1]); end
    checks++; if (got_gnt[2] !== 4'b0001 || got_word[2] !== 32'd1712068217) begin failures++; $display("FAIL sh_grant2: got %b/%0d expected 0001/1712068217", got_gnt[2], got_word[2]); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    do_reset();
    @(negedge clk);
    req = 4'b1111;
    observe(8, 20);
    checks++; if (got_n !== 8) begin failures++; $display("FAIL rr_count: got %0d expected 8", got_n); end
    for (int k = 0; k < 8; k++) begin
      exp_g = 4'b0001 << (k % 4);
      checks++; if (got_gnt[k] !== exp_g) begin failures++; $display("FAIL rr_order%0d: got %b expected %b", k, got_gnt[k], exp_g); end
    end
    req = 4'b1010;
    observe(4, 20);
    req = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 4'b0010 : 4'b1000;
      checks++; if (got_gnt[k] !== exp_g) begin failures++; $display("FAIL rr_sparse%0d: got %b expected %b", k, got_gnt[k], exp_g); end
    end
  endtask

  task automatic test_back_to_back();
    int e0;
    @(negedge clk);
    req         = 4'b0001;
    reseed_req  = 1'b1;
    reseed_seed = 32'hCAFE_BABE;
    e0          = reseed_edges;
    @(negedge clk);
    checks++; if (reseed_ack !== 1'b1 || taus_seed !== 32'hCAFE_BABE) begin failures++; $display("FAIL b2b_ack1: got %b/%h expected 1/cafebabe", reseed_ack, taus_seed); end
    reseed_req = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_settle_busy: got %b expected 1", busy); end
    reseed_req  = 1'b1;
    reseed_seed = 32'hDEAD_BEEF;
    observe(1, 20);
    req = 4'b0000;
    checks++; if (ack_n !== 1) begin failures++; $display("FAIL b2b_ack2: got %0d expected 1", ack_n); end
    checks++; if (busy_n !== 4) begin failures++; $display("FAIL b2b_busy: got %0d expected 4", busy_n); end
    checks++; if (got_n !== 1 || got_word[0] !== 32'd3687771566) begin failures++; $display("FAIL b2b_word: got %0d/%0d expected 1/3687771566", got_n, got_word[0]); end
    checks++; if (reseed_edges - e0 !== 2) begin failures++; $display("FAIL b2b_edges: got %0d expected 2", reseed_edges - e0); end
    // A single CAFEBABE reseed on its own.
    @(negedge clk);
    req         = 4'b0001;
    reseed_req  = 1'b1;
    reseed_seed = 32'hCAFE_BABE;
    observe(1, 20);
    req = 4'b0000;
    checks++; if (got_n !== 1 || got_word[0] !== 32'd3951813429) begin failures++; $display("FAIL cafe_word: got %0d/%0d expected 1/3951813429", got_n, got_word[0]); end
  endtask

  task automatic test_async_reset();
    int e0;
    @(negedge clk);
    req = 4'b0001;
    @(negedge clk);
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL ar_pre_gnt: got %b expected %b", gnt, 4'b0001); end
    #2 rst_n = 1'b0;
    req = 4'b0000;
    #1;
    checks++; if (gnt !== 4'b0000 || rnd_valid !== 1'b0 || rnd_data !== 32'h0) begin failures++; $display("FAIL ar_grant_clear: got %b/%b/%h expected 0000/0/0", gnt, rnd_valid, rnd_data); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    reseed_req  = 1'b1;
    reseed_seed = 32'hDEAD_BEEF;
    @(negedge clk);
    reseed_req = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ar_pre_busy: got %b expected 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || gnt !== 4'b0000) begin failures++; $display("FAIL ar_settle_clear: got busy %b gnt %b expected 0/0000", busy, gnt); end
    checks++; if (taus_seed !== 32'h0 || taus_re_seed !== 1'b0) begin failures++; $display("FAIL ar_seed_clear: got %h/%b expected 0/0", taus_seed, taus_re_seed); end
    e0 = reseed_edges;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0100;
    observe(1, 10);
    req = 4'b0000;
    checks++; if (got_n !== 1 || got_gnt[0] !== 4'b0100) begin failures++; $display("FAIL ar_regrant: got %0d/%b expected 1/0100", got_n, got_gnt[0]); end
    checks++; if (reseed_edges !== e0 || ack_n !== 0) begin failures++; $display("FAIL ar_no_reseed: got %0d/%0d expected %0d/0", reseed_edges, ack_n, e0); end
  endtask

`ifdef TAUS_SCHED_STATS_EN
  task automatic test_stats();
    do_reset();
    checks++; if (stat_cnt !== '0) begin failures++; $display("FAIL st_reset: got %h expected 0", stat_cnt); end
    @(negedge clk);
    req = 4'b0100;
    @(negedge clk);
    req = 4'b0000;
    checks++; if (stat_cnt[2*STAT_W +: STAT_W] !== 16'd0) begin failures++; $display("FAIL st_before: got %0d expected 0", stat_cnt[2*STAT_W +: STAT_W]); end
    @(negedge clk);
    checks++; if (stat_cnt[2*STAT_W +: STAT_W] !== 16'd1) begin failures++; $display("FAIL st_incr: got %0d expected 1", stat_cnt[2*STAT_W +: STAT_W]); end
    req = 4'b0100;
    @(negedge clk);
    req      = 4'b0000;
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    checks++; if (stat_cnt !== '0) begin failures++; $display("FAIL st_clr_wins: got %h expected 0", stat_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_first_grant();
    test_reseed_single();
    test_reseed_shared();
    test_round_robin();
    test_back_to_back();
    test_async_reset();
`ifdef TAUS_SCHED_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
